// File: rtl/pcm_dc_block_if.sv
// Output stream of pcm_dc_block: one filtered sample per transfer, tagged with its channel.
// Valid/ready handshake; a transfer completes when out_valid && out_ready.
interface pcm_dc_block_if #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 2
);
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_chan;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output out_data,
    output out_chan,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_chan,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/pcm_dc_block.sv
// Per-channel first-order DC-blocking high-pass on NCH PCM channels, serialised over valid/ready.
// Optional macro DCB_BYPASS_EN adds a bypass input that passes raw samples while the filter keeps running.
module pcm_dc_block #(
  parameter int unsigned NCH = 3,
  parameter int unsigned W   = 16,
  parameter int unsigned K   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_pcm,
  input  logic [NCH*W-1:0]    pcm_in,
`ifdef DCB_BYPASS_EN
  input  logic                bypass,
`endif
  pcm_dc_block_if.master      out_if,
  output logic                overrun
);

  localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned AW = W + K + 2;
  localparam int          MaxI = 2 ** (W - 1) - 1;
  localparam logic signed [AW-1:0] SatHi = AW'(MaxI);
  localparam logic signed [AW-1:0] SatLo = AW'(-MaxI - 1);
  localparam logic [CW-1:0] LastCh = CW'(NCH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StEmit} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             sync_q;
  logic [CW-1:0]          ch_q, ch_d;
  logic [W-1:0]           snap_q [NCH];
  logic [W-1:0]           snap_d [NCH];
  logic [W-1:0]           x_prev_q [NCH];
  logic [W-1:0]           x_prev_d [NCH];
  logic signed [AW-1:0]   acc_q [NCH];
  logic signed [AW-1:0]   acc_d [NCH];
  logic [W-1:0]           data_q, data_d;
  logic [CW-1:0]          chan_q, chan_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
`ifdef DCB_BYPASS_EN
  logic                   bypass_q, bypass_d;
`endif

  logic                   pcm_edge;
  logic [W-1:0]           snap_cur;
  logic [W-1:0]           xp_cur;
  logic signed [AW-1:0]   acc_cur;
  logic signed [W:0]      diff;
  logic signed [AW-1:0]   diff_ext;
  logic signed [AW-1:0]   acc_n;
  logic signed [AW-1:0]   y_full;
  logic [W-1:0]           y_sat;

  // sync_q[1] is the second synchroniser stage, sync_q[2] its delayed copy.
  assign pcm_edge = sync_q[1] & ~sync_q[2];

  // Filter datapath for the channel currently being computed; acc holds y scaled by 2^K.
  always_comb begin
    snap_cur = snap_q[ch_q];
    xp_cur   = x_prev_q[ch_q];
    acc_cur  = acc_q[ch_q];
    diff     = {snap_cur[W-1], snap_cur} - {xp_cur[W-1], xp_cur};
    diff_ext = {{(AW - W - 1){diff[W]}}, diff};
    acc_n    = acc_cur + (diff_ext <<< K) - (acc_cur >>> K);
    y_full   = acc_n >>> K;
    if (y_full > SatHi) begin
      y_sat = SatHi[W-1:0];
    end else if (y_full < SatLo) begin
      y_sat = SatLo[W-1:0];
    end else begin
      y_sat = y_full[W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    snap_d    = snap_q;
    x_prev_d  = x_prev_q;
    acc_d     = acc_q;
    data_d    = data_q;
    chan_d    = chan_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
`ifdef DCB_BYPASS_EN
    bypass_d  = bypass_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pcm_edge) begin
          for (int c = 0; c < NCH; c++) begin
            snap_d[c] = pcm_in[c*W +: W];
          end
`ifdef DCB_BYPASS_EN
          bypass_d = bypass;
`endif
          ch_d    = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d[ch_q]    = acc_n;
        x_prev_d[ch_q] = snap_cur;
`ifdef DCB_BYPASS_EN
        data_d = bypass_q ? snap_cur : y_sat;
`else
        data_d = y_sat;
`endif
        chan_d  = ch_q;
        valid_d = 1'b1;
        state_d = StEmit;
      end
      StEmit: begin
        if (out_if.out_ready) begin
          valid_d = 1'b0;
          if (ch_q == LastCh) begin
            state_d = StIdle;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = StCalc;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A new frame arriving while busy is dropped, including on the cycle of the final accept.
    if (pcm_edge && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      ch_q      <= '0;
      snap_q    <= '{default: '0};
      x_prev_q  <= '{default: '0};
      acc_q     <= '{default: '0};
      data_q    <= '0;
      chan_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef DCB_BYPASS_EN
      bypass_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], clk_pcm};
      ch_q      <= ch_d;
      snap_q    <= snap_d;
      x_prev_q  <= x_prev_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef DCB_BYPASS_EN
      bypass_q  <= bypass_d;
`endif
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_chan  = chan_q;
  assign out_if.out_valid = valid_q;
  assign overrun          = overrun_q;

endmodule

// File: doc/pcm_dc_block.md
Name: pcm_dc_block

Overview:
- Sits between the PCM outputs of the cic decimators and the doa stage.
- Snapshots NCH 16-bit PCM channels on each clk_pcm rising edge, removes DC with a first-order high-pass (y = x - x' + a*y', a = 1 - 2^-K), and streams results one channel at a time over a valid/ready interface.
- Runs entirely in the clk domain; clk_pcm is treated as a slow strobe and synchronised internally.

Parameters:
- NCH, 3, number of PCM channels.
- W, 16, sample width (signed two's complement).
- K, 8, pole shift; a = 1 - 2^-K.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_pcm  in  1  PCM frame clock from audio_clock
- pcm_in  in  NCH*W  channel c at bits [c*W +: W]
- out_data  out  W  filtered sample, signed
- out_chan  out  max(1,$clog2(NCH))  channel index of out_data
- out_valid  out  1  out_data/out_chan valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- overrun  out  1  sticky: a frame was dropped

Behaviour:
- Reset (reset=0, async):
  - out_valid=0, out_data=0, out_chan=0, overrun=0.
  - Sync flops=0; all per-channel x_prev and acc cleared; FSM=IDLE.
  - Reset mid-frame abandons the frame; no partial output after release.
- clk_pcm passes a 2-flop synchroniser plus a delayed copy. Rising edge detect = s2 & ~s3 (cycle E).
- IDLE, edge at E:
  - pcm_in captured into snap[NCH] at E; ch=0; FSM->CALC.
- CALC (1 cycle per channel), per channel:
  - acc is signed, W+K+2 bits, and holds y*2^K.
  - d = sext(snap[ch]) - sext(x_prev[ch]), W+1 bits.
  - acc_n = acc[ch] + (d <<< K) - (acc[ch] >>> K), arithmetic shift.
  - acc[ch] <= acc_n; x_prev[ch] <= snap[ch].
  - out_data <= saturate(acc_n >>> K) to [-2^(W-1), 2^(W-1)-1].
  - out_chan <= ch; out_valid <= 1; FSM->EMIT.
- EMIT:
  - Hold out_data, out_chan and out_valid stable until out_ready=1.
  - On accept: out_valid <= 0.
  - If ch==NCH-1: FSM->IDLE; else ch++, FSM->CALC.
  - out_valid never asserts in the cycle directly after an accept.
- Latency, zero backpressure: channel 0 valid at E+2; channel c valid at E+2+2c; full frame done by E+2*NCH.
- Overrun:
  - An edge detected while FSM != IDLE drops the new frame: snap and state are untouched and the current frame completes.
  - overrun <= 1 and stays set until reset.
  - An edge in the same cycle as the final accept also counts as overrun; IDLE is only entered on the following cycle.
- Channel order is always 0..NCH-1; no channel is skipped.

Optional Feature:
- Macro DCB_BYPASS_EN.
- Defined:
  - Adds input port bypass (1 bit), sampled at edge cycle E together with snap.
  - When the latched bypass=1, CALC drives out_data = snap[ch] unmodified.
  - acc and x_prev still update exactly as normal, so leaving bypass causes no transient.
- Undefined: no bypass port; the filter is always applied.

Test Plan:
- Reset release, no clk_pcm edges -> out_valid=0, overrun=0, out_data=0 indefinitely.
- Step on ch0, K=8: ch0 held at 1000, out_ready=1 -> ch0 outputs 1000, 996, 992, ... Then monotonic decay toward 0; ch1/ch2 at 0 output 0; out_chan sequence 0,1,2 per frame.
- Saturation: ch0 jumps -32768 -> +32767 between frames -> out_data clamps to 32767 (no wrap). The reverse jump clamps to -32768.
- Backpressure: out_ready=0 for 10 cycles after channel 0 valid -> out_data/out_chan stable, no extra outputs. Channels 1, 2 then follow in order after out_ready=1.
- Overrun: hold out_ready=0 across the next clk_pcm edge -> overrun=1 sticky; the dropped frame produces no outputs; the in-flight frame completes intact. Only reset clears overrun.
- Async reset mid-EMIT: assert reset low during EMIT -> out_valid=0 immediately. After release, the first frame of constant 500 yields 500 on every channel, confirming the filter state was cleared.
